store_commit_buffer: RTL and testbench

STORE_COMMIT_BUFFER -- requirements
Module: store_commit_buffer

---
 rtl/store_commit_buffer.sv | 91 +++++++++
 tb/tb_store_commit_buffer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/store_commit_buffer.sv
// Store commit buffer: in-order FIFO of retired stores draining to data memory.
// Optional store-to-load forwarding is built only when STORE_FWD_EN is defined.
module store_commit_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_st_valid,
    input  logic [31:0]              i_st_addr,
    input  logic [31:0]              i_st_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_mem_wr_en,
    output logic [31:0]              o_mem_addr,
    output logic [31:0]              o_mem_data,
    input  logic                     i_mem_ready,
    input  logic [31:0]              i_ld_addr,
    output logic                     o_fwd_hit,
    output logic [31:0]              o_fwd_data
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic          push, pop;

    // Wrap bit (MSB) distinguishes full from empty when the index bits match.
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = ({~wr_ptr[PW-1], wr_ptr[IW-1:0]} == rd_ptr);
    assign o_count = wr_ptr - rd_ptr;

    // A full buffer never accepts a store, even when a pop frees a slot this cycle.
    assign push = i_st_valid && !o_full;
    assign pop  = o_mem_wr_en && i_mem_ready;

    assign o_mem_wr_en = !o_empty;
    assign o_mem_addr  = o_empty ? 32'd0 : addr_q[rd_ptr[IW-1:0]];
    assign o_mem_data  = o_empty ? 32'd0 : data_q[rd_ptr[IW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: entry storage has no reset; validity comes from the pointers alone.
    always_ff @(posedge i_clk) begin
        if (push) begin
            addr_q[wr_ptr[IW-1:0]] <= i_st_addr;
            data_q[wr_ptr[IW-1:0]] <= i_st_data;
        end
    end

`ifdef STORE_FWD_EN
    logic [IW-1:0] fwd_idx;
    logic          unused_ld;

    assign unused_ld = ^i_ld_addr[1:0];

    // Scan oldest to youngest so the last match wins; the entry being pushed is not yet visible.
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        o_fwd_hit  = 1'b0;
        o_fwd_data = 32'd0;
        fwd_idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = rd_ptr[IW-1:0] + IW'(k);
            if ((PW'(k) < o_count) && (addr_q[fwd_idx][31:2] == i_ld_addr[31:2])) begin
                o_fwd_hit  = 1'b1;
                o_fwd_data = data_q[fwd_idx];
            end
        end
    end
`else
    logic unused_ld;

    assign unused_ld  = ^i_ld_addr;
    assign o_fwd_hit  = 1'b0;
    assign o_fwd_data = 32'd0;
`endif

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed self-checking bench for store_commit_buffer (DEPTH = 4).
// Forwarding expectations follow the STORE_FWD_EN build setting.
module tb_store_commit_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic [31:0] st_addr, st_data;
    logic        full, empty;
    logic [2:0]  count;
    logic        mem_wr_en;
    logic [31:0] mem_addr, mem_data;
    logic        mem_ready;
    logic [31:0] ld_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    int passed = 0;
    int total  = 0;

    store_commit_buffer #(.DEPTH(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_st_valid  (st_valid),
        .i_st_addr   (st_addr),
        .i_st_data   (st_data),
        .o_full      (full),
        .o_empty     (empty),
        .o_count     (count),
        .o_mem_wr_en (mem_wr_en),
        .o_mem_addr  (mem_addr),
        .o_mem_data  (mem_data),
        .i_mem_ready (mem_ready),
        .i_ld_addr   (ld_addr),
        .o_fwd_hit   (fwd_hit),
        .o_fwd_data  (fwd_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_store(input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        tick();
        st_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
        mem_ready = 1'b0; ld_addr = 32'h0;
        #2;
        total++; if ({empty, full, count, mem_wr_en} !== 6'b1_0_000_0) $display("FAIL reset_flags: got e=%b f=%b c=%0d w=%b expected e=1 f=0 c=0 w=0", empty, full, count, mem_wr_en); else passed++;
        total++; if ({mem_addr, mem_data} !== 64'd0) $display("FAIL reset_mem_bus: got %h/%h expected 0/0", mem_addr, mem_data); else passed++;
        total++; if ({fwd_hit, fwd_data} !== 33'd0) $display("FAIL reset_fwd: got %b/%h expected 0/0", fwd_hit, fwd_data); else passed++;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_push();
        st_valid = 1'b1; st_addr = 32'h100; st_data = 32'hAAAA; mem_ready = 1'b0;
        #1;
        total++; if (mem_wr_en !== 1'b0) $display("FAIL no_bypass: got wr_en=%b expected 0", mem_wr_en); else passed++;
        tick();
        st_valid = 1'b0;
        #1;
        total++; if (mem_wr_en !== 1'b1) $display("FAIL single_wr_en: got %b expected 1", mem_wr_en); else passed++;
        total++; if ({mem_addr, mem_data} !== {32'h100, 32'hAAAA}) $display("FAIL single_head: got %h/%h expected 100/aaaa", mem_addr, mem_data); else passed++;
        total++; if (count !== 3'd1) $display("FAIL single_count: got %0d expected 1", count); else passed++;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        total++; if (empty !== 1'b1) $display("FAIL single_drain: got empty=%b expected 1", empty); else passed++;
    endtask

    task automatic test_fill_drain();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_store(32'h1000 + 32'(4*i), 32'hD000 + 32'(i));
        total++; if ({full, count} !== 4'b1_100) $display("FAIL fill_full: got f=%b c=%0d expected f=1 c=4", full, count); else passed++;
        push_store(32'hDEAD, 32'hBEEF);
        total++; if (count !== 3'd4) $display("FAIL fill_fifth_ignored: got %0d expected 4", count); else passed++;
        total++; if ({mem_addr, mem_data} !== {32'h1000, 32'hD000}) $display("FAIL fill_stable: got %h/%h expected 1000/d000", mem_addr, mem_data); else passed++;
        mem_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            total++; if ({mem_addr, mem_data} !== {32'h1000 + 32'(4*i), 32'hD000 + 32'(i)}) $display("FAIL drain_order[%0d]: got %h/%h expected %h/%h", i, mem_addr, mem_data, 32'h1000 + 32'(4*i), 32'hD000 + 32'(i)); else passed++;
            tick();
        end
        mem_ready = 1'b0;
        total++; if ({empty, mem_wr_en} !== 2'b10) $display("FAIL drain_empty: got e=%b w=%b expected e=1 w=0", empty, mem_wr_en); else passed++;
    endtask

    task automatic test_full_push_pop();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_store(32'h2000 + 32'(4*i), 32'hC000 + 32'(i));
        st_valid = 1'b1; st_addr = 32'hBAD0; st_data = 32'hBAD; mem_ready = 1'b1;
        tick();
        st_valid = 1'b0;
        #1;
        total++; if ({full, count} !== 4'b0_011) $display("FAIL fullpp_count: got f=%b c=%0d expected f=0 c=3", full, count); else passed++;
        for (int i = 1; i < 4; i++) begin
            total++; if ({mem_addr, mem_data} !== {32'h2000 + 32'(4*i), 32'hC000 + 32'(i)}) $display("FAIL fullpp_order[%0d]: got %h/%h expected %h/%h", i, mem_addr, mem_data, 32'h2000 + 32'(4*i), 32'hC000 + 32'(i)); else passed++;
            tick();
        end
        mem_ready = 1'b0;
        total++; if (empty !== 1'b1) $display("FAIL fullpp_not_stored: got empty=%b expected 1", empty); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] qa[$];
        logic [31:0] qd[$];
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            push_store(32'h3000 + 32'(4*i), 32'hE000 + 32'(i));
            qa.push_back(32'h3000 + 32'(4*i));
            qd.push_back(32'hE000 + 32'(i));
        end
        for (int i = 2; i < 12; i++) begin
            st_valid = 1'b1; st_addr = 32'h3000 + 32'(4*i); st_data = 32'hE000 + 32'(i); mem_ready = 1'b1;
            #1;
            total++; if ({mem_addr, mem_data} !== {qa[0], qd[0]}) $display("FAIL b2b_head[%0d]: got %h/%h expected %h/%h", i, mem_addr, mem_data, qa[0], qd[0]); else passed++;
            qa.push_back(st_addr); qd.push_back(st_data);
            void'(qa.pop_front()); void'(qd.pop_front());
            tick();
            total++; if (count !== 3'd2) $display("FAIL b2b_count[%0d]: got %0d expected 2", i, count); else passed++;
        end
        st_valid = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            total++; if ({mem_addr, mem_data} !== {qa[i], qd[i]}) $display("FAIL b2b_tail[%0d]: got %h/%h expected %h/%h", i, mem_addr, mem_data, qa[i], qd[i]); else passed++;
            tick();
        end
        mem_ready = 1'b0;
        total++; if (empty !== 1'b1) $display("FAIL b2b_empty: got %b expected 1", empty); else passed++;
    endtask

    task automatic test_forwarding();
        mem_ready = 1'b0;
        push_store(32'h200, 32'h11);
        push_store(32'h204, 32'h22);
        push_store(32'h202, 32'h33);
`ifdef STORE_FWD_EN
        ld_addr = 32'h200; #1;
        total++; if ({fwd_hit, fwd_data} !== {1'b1, 32'h33}) $display("FAIL fwd_youngest: got %b/%h expected 1/33", fwd_hit, fwd_data); else passed++;
        ld_addr = 32'h206; #1;
        total++; if ({fwd_hit, fwd_data} !== {1'b1, 32'h22}) $display("FAIL fwd_word: got %b/%h expected 1/22", fwd_hit, fwd_data); else passed++;
        ld_addr = 32'h300; st_valid = 1'b1; st_addr = 32'h300; st_data = 32'h44; #1;
        total++; if (fwd_hit !== 1'b0) $display("FAIL fwd_miss_same_cycle_push: got %b expected 0", fwd_hit); else passed++;
        tick();
        st_valid = 1'b0; #1;
        total++; if ({fwd_hit, fwd_data} !== {1'b1, 32'h44}) $display("FAIL fwd_after_push: got %b/%h expected 1/44", fwd_hit, fwd_data); else passed++;
        ld_addr = 32'h204; mem_ready = 1'b1;
        tick();
        tick();
        total++; if ({fwd_hit, fwd_data} !== {1'b0, 32'h0}) $display("FAIL fwd_after_pop: got %b/%h expected 0/0", fwd_hit, fwd_data); else passed++;
        ld_addr = 32'h300; #1;
        total++; if ({fwd_hit, fwd_data} !== {1'b1, 32'h44}) $display("FAIL fwd_popping_head: got %b/%h expected 1/44", fwd_hit, fwd_data); else passed++;
        tick();
        tick();
`else
        ld_addr = 32'h200; #1;
        total++; if ({fwd_hit, fwd_data} !== 33'd0) $display("FAIL fwd_disabled: got %b/%h expected 0/0", fwd_hit, fwd_data); else passed++;
        mem_ready = 1'b1;
        tick(); tick(); tick();
`endif
        mem_ready = 1'b0; ld_addr = 32'h0;
        total++; if (empty !== 1'b1) $display("FAIL fwd_drain_empty: got %b expected 1", empty); else passed++;
    endtask

    task automatic test_reset_mid();
        mem_ready = 1'b0;
        push_store(32'h400, 32'h1);
        push_store(32'h404, 32'h2);
        push_store(32'h408, 32'h3);
        ld_addr = 32'h400;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if ({empty, full, count, mem_wr_en} !== 6'b1_0_000_0) $display("FAIL midrst_flags: got e=%b f=%b c=%0d w=%b expected e=1 f=0 c=0 w=0", empty, full, count, mem_wr_en); else passed++;
        total++; if ({mem_addr, mem_data, fwd_hit, fwd_data} !== 97'd0) $display("FAIL midrst_outputs: got %h/%h/%b/%h expected all 0", mem_addr, mem_data, fwd_hit, fwd_data); else passed++;
        tick();
        rst_n = 1'b1;
        mem_ready = 1'b1;
        tick();
        total++; if ({mem_wr_en, empty} !== 2'b01) $display("FAIL midrst_no_stale: got w=%b e=%b expected w=0 e=1", mem_wr_en, empty); else passed++;
        mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_drain();
        test_full_push_pop();
        test_back_to_back();
        test_forwarding();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
